// File: rtl/axi_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 manager port.
package axi_master_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;

    // Response severity follows the encoding order, so "worst" is a plain max.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master_if.sv
// AXI4 manager port: one read or write burst in flight, AW strictly before W.
// Optional error log (err_flag/err_addr) built when AXI_MASTER_ERRLOG_EN is defined.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a core request
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | RREADY high, beats forwarded to core until RLAST
// WR_ADDR | AWVALID held until AWREADY
// WR_DATA | core write stream passed through to W, WLAST on beat len
// WR_RESP | BREADY high until the B handshake
module axi_master_if
    import axi_master_pkg::*;
#(
    parameter int MASTER_ID = 0,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [3:0]                req_len,

    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_W-1:0]         wd_data,
    input  logic [DATA_W/8-1:0]       wd_strb,

    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_last,

    output logic                      done,
    output logic [1:0]                done_resp,
`ifdef AXI_MASTER_ERRLOG_EN
    output logic                      err_flag,
    output logic [ADDR_W-1:0]         err_addr,
`endif

    output logic [AXI_ID_BITS-1:0]    ARID,
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [AXI_LEN_BITS-1:0]   ARLEN,
    output logic [AXI_SIZE_BITS-1:0]  ARSIZE,
    output logic [AXI_BURST_BITS-1:0] ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [AXI_ID_BITS-1:0]    RID,
    input  logic [DATA_W-1:0]         RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,

    output logic [AXI_ID_BITS-1:0]    AWID,
    output logic [ADDR_W-1:0]         AWADDR,
    output logic [AXI_LEN_BITS-1:0]   AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [AXI_BURST_BITS-1:0] AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [DATA_W-1:0]         WDATA,
    output logic [DATA_W/8-1:0]       WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [AXI_ID_BITS-1:0]    BID,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY
);

    localparam logic [AXI_ID_BITS-1:0] ID_VAL = AXI_ID_BITS'(MASTER_ID);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_cnt;
    logic [1:0]          resp_acc;
    logic                req_ready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wr_phase_q;
    logic                bready_q;
    logic                done_q;
    logic [1:0]          done_resp_q;

    logic                w_hs;
    logic                r_cnt_err;
    logic [1:0]          r_resp_next;
    logic [1:0]          b_resp_next;
    logic                finish;
    logic [1:0]          fin_resp;

    assign ARID    = ID_VAL;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = ID_VAL;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = awvalid_q;

    assign WVALID   = wr_phase_q & wd_valid;
    assign wd_ready = wr_phase_q & WREADY;
    assign WDATA    = wd_data;
    assign WSTRB    = wd_strb;
    assign WLAST    = wr_phase_q & (beat_cnt == len_q);
    assign BREADY   = bready_q;

    assign rd_valid  = rready_q & RVALID;
    assign rd_data   = RDATA;
    assign rd_last   = rready_q & RLAST;
    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;

    assign w_hs = WVALID & WREADY;

    // Early RLAST, or a beat beyond len without RLAST, both count as a length error.
    assign r_cnt_err   = RLAST ? (beat_cnt != len_q) : (beat_cnt == len_q);
    assign r_resp_next = worst_resp(worst_resp(resp_acc, RRESP),
                                    worst_resp((RID != ID_VAL) ? RESP_SLVERR : RESP_OKAY,
                                               r_cnt_err ? RESP_SLVERR : RESP_OKAY));
    assign b_resp_next = worst_resp(worst_resp(resp_acc, BRESP),
                                    (BID != ID_VAL) ? RESP_SLVERR : RESP_OKAY);

    assign finish   = ((state == RD_DATA) & RVALID & RLAST) | ((state == WR_RESP) & BVALID);
    assign fin_resp = (state == WR_RESP) ? b_resp_next : r_resp_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            resp_acc    <= RESP_OKAY;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wr_phase_q  <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= RESP_OKAY;
        end else begin
            done_q <= 1'b0;
            if (finish) begin
                done_q      <= 1'b1;
                done_resp_q <= fin_resp;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        len_q       <= req_len;
                        beat_cnt    <= '0;
                        resp_acc    <= RESP_OKAY;
                        req_ready_q <= 1'b0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            state     <= WR_ADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        resp_acc <= r_resp_next;
                        if (RLAST) begin
                            rready_q    <= 1'b0;
                            req_ready_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WR_ADDR: begin
                    if (AWREADY) begin
                        awvalid_q  <= 1'b0;
                        wr_phase_q <= 1'b1;
                        state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (WLAST) begin
                            wr_phase_q <= 1'b0;
                            bready_q   <= 1'b1;
                            state      <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        bready_q    <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef AXI_MASTER_ERRLOG_EN
    logic              err_flag_q;
    logic [ADDR_W-1:0] err_addr_q;

    // Only the first failing transaction is logged; it sticks until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (finish && (fin_resp >= RESP_SLVERR) && !err_flag_q) begin
            err_flag_q <= 1'b1;
            err_addr_q <= addr_q;
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_axi_master_if.sv
// Directed bench for axi_master_if; error-log ports are checked when AXI_MASTER_ERRLOG_EN is defined.
module tb_axi_master_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;
`ifdef AXI_MASTER_ERRLOG_EN
    logic        err_flag;
    logic [31:0] err_addr;
`endif
    logic [3:0]  ARID, RID, AWID, BID;
    logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    int n_cmp = 0;
    int n_bad = 0;

    axi_master_if #(.MASTER_ID(0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
`ifdef AXI_MASTER_ERRLOG_EN
        .err_flag(err_flag), .err_addr(err_addr),
`endif
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic issue_req(input logic w, input logic [31:0] addr, input logic [3:0] len);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = addr;
        req_len   = len;
        #1 check_val("req_ready_before_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check_val("req_ready_busy", req_ready, 0);
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [3:0] len, input int ar_delay,
                            input logic [3:0] rid, input logic [1:0] rresp,
                            input logic [31:0] d0, input logic [1:0] exp_resp);
        int held;
        issue_req(1'b0, addr, len);
        check_val("arvalid_next_cycle", ARVALID, 1);
        check_val("araddr", ARADDR, addr);
        check_val("arlen", ARLEN, len);
        check_val("arsize", ARSIZE, 3'b010);
        check_val("arburst", ARBURST, 2'b01);
        check_val("arid", ARID, 0);
        check_val("rready_in_rd_addr", RREADY, 0);
        held = 0;
        for (int i = 0; i <= ar_delay; i++) begin
            if (ARVALID === 1'b1) held++;
            check_val("araddr_stable", ARADDR, addr);
            if (i == ar_delay) ARREADY = 1'b1;
            @(negedge clk);
            ARREADY = 1'b0;
        end
        check_val("arvalid_held_cycles", held, ar_delay + 1);
        #1 check_val("arvalid_dropped", ARVALID, 0);
        check_val("rready_in_rd_data", RREADY, 1);
        for (int b = 0; b <= int'(len); b++) begin
            RVALID = 1'b1;
            RID    = rid;
            RRESP  = rresp;
            RDATA  = d0 + 32'(b);
            RLAST  = (b == int'(len));
            #1;
            check_val("rd_valid", rd_valid, 1);
            check_val("rd_data", rd_data, d0 + 32'(b));
            check_val("rd_last", rd_last, (b == int'(len)));
            check_val("done_during_burst", done, 0);
            @(negedge clk);
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        #1;
        check_val("rd_done", done, 1);
        check_val("rd_done_resp", done_resp, exp_resp);
        check_val("rready_after_done", RREADY, 0);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [3:0] len, input int stall_beat,
                             input int stall_cyc, input logic [1:0] bresp,
                             input logic [31:0] d0, input logic [1:0] exp_resp);
        int b, st, wl;
        issue_req(1'b1, addr, len);
        wd_valid = 1'b1;
        wd_data  = d0;
        wd_strb  = 4'hF;
        WREADY   = 1'b1;
        #1;
        check_val("awvalid", AWVALID, 1);
        check_val("awaddr", AWADDR, addr);
        check_val("awlen", AWLEN, len);
        check_val("awsize", AWSIZE, 3'b010);
        check_val("wvalid_before_aw", WVALID, 0);
        AWREADY = 1'b1;
        @(negedge clk);
        AWREADY = 1'b0;
        #1 check_val("awvalid_dropped", AWVALID, 0);
        b = 0; st = 0; wl = 0;
        for (int cyc = 0; cyc < 40 && b <= int'(len); cyc++) begin
            wd_data = d0 + 32'(b);
            WREADY  = !(b == stall_beat && st < stall_cyc);
            #1;
            check_val("wvalid", WVALID, 1);
            check_val("wdata", WDATA, d0 + 32'(b));
            check_val("wstrb", WSTRB, 4'hF);
            check_val("wd_ready", wd_ready, WREADY);
            check_val("wlast", WLAST, (b == int'(len)));
            if (WREADY && WLAST) wl++;
            @(negedge clk);
            if (WREADY) b++; else st++;
        end
        check_val("w_beats", b, int'(len) + 1);
        check_val("w_stall_cycles", st, stall_cyc);
        wd_valid = 1'b0;
        WREADY   = 1'b0;
        #1;
        check_val("wlast_count", wl, 1);
        check_val("bready", BREADY, 1);
        check_val("wvalid_in_resp", WVALID, 0);
        BVALID = 1'b1;
        BRESP  = bresp;
        BID    = 4'd0;
        @(negedge clk);
        BVALID = 1'b0;
        #1;
        check_val("wr_done", done, 1);
        check_val("wr_done_resp", done_resp, exp_resp);
        check_val("bready_after_done", BREADY, 0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0;
        ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
        repeat (2) @(negedge clk);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_arvalid", ARVALID, 0);
        check_val("rst_awvalid", AWVALID, 0);
        check_val("rst_wvalid", WVALID, 0);
        check_val("rst_rready", RREADY, 0);
        check_val("rst_bready", BREADY, 0);
        check_val("rst_done", done, 0);
        check_val("rst_done_resp", done_resp, 0);
        check_val("rst_araddr", ARADDR, 0);
        check_val("rst_arlen", ARLEN, 0);
`ifdef AXI_MASTER_ERRLOG_EN
        check_val("rst_err_flag", err_flag, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        read_txn(32'h0000_1000, 4'd0, 2, 4'd0, 2'b00, 32'hDEAD_BEEF, 2'b00);
        @(negedge clk);
        #1 check_val("done_one_cycle", done, 0);
        check_val("done_resp_holds", done_resp, 0);

        write_txn(32'h0000_2000, 4'd3, 1, 3, 2'b00, 32'h0000_00A0, 2'b00);
        @(negedge clk);

        read_txn(32'h8000_0040, 4'd3, 0, 4'd0, 2'b00, 32'h1111_0000, 2'b00);
        @(negedge clk);
`ifdef AXI_MASTER_ERRLOG_EN
        check_val("err_flag_clean", err_flag, 0);
`endif

        read_txn(32'hF000_0000, 4'd0, 1, 4'd0, 2'b11, 32'h0, 2'b11);
        @(negedge clk);
`ifdef AXI_MASTER_ERRLOG_EN
        check_val("err_flag_decerr", err_flag, 1);
        check_val("err_addr_decerr", err_addr, 32'hF000_0000);
`endif

        // Wrong RID, then back-to-back into a clean read in the same cycle done is high.
        read_txn(32'h0000_3000, 4'd0, 0, 4'd5, 2'b00, 32'h5555_5555, 2'b10);
        read_txn(32'h0000_3100, 4'd1, 0, 4'd0, 2'b00, 32'h7777_0000, 2'b00);
`ifdef AXI_MASTER_ERRLOG_EN
        check_val("err_addr_sticky", err_addr, 32'hF000_0000);
`endif
        @(negedge clk);

        // Reset asserted while the second write beat is stalled.
        issue_req(1'b1, 32'h0000_4000, 4'd3);
        wd_valid = 1'b1; wd_data = 32'hC0; wd_strb = 4'hF;
        AWREADY = 1'b1;
        @(negedge clk);
        AWREADY = 1'b0;
        WREADY  = 1'b1;
        @(negedge clk);
        WREADY  = 1'b0;
        wd_data = 32'hC1;
        #1 check_val("wvalid_before_rst", WVALID, 1);
        #1 rst = 1'b0;
        #1;
        check_val("midrst_wvalid", WVALID, 0);
        check_val("midrst_awvalid", AWVALID, 0);
        check_val("midrst_bready", BREADY, 0);
        check_val("midrst_req_ready", req_ready, 1);
`ifdef AXI_MASTER_ERRLOG_EN
        check_val("midrst_err_flag", err_flag, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        wd_valid = 1'b0;
        @(negedge clk);
        read_txn(32'h0000_5000, 4'd0, 1, 4'd0, 2'b00, 32'hCAFE_F00D, 2'b00);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
